// File: rtl/adc_scan_ctrl.sv
// ---------------------------------------------------------------------------
// adc_scan_ctrl
//
// Autonomous multi-channel scan controller for an LTC2308-style SPI ADC.
// Round-robins over the channels enabled in ch_mask, generates a registered
// serial clock (no gated clocks), tracks the ADC's one-frame configuration
// pipeline and hands channel-tagged results downstream over valid/ready.
//
// Frame: CONVST (1) -> CONV_WAIT (CONV_CYC) -> SHIFT (2*SCK_DIV*DATA_W) -> DONE (1)
//
// Parameters:
//   DATA_W   result bits per frame / SCK pulses per frame (6..16)
//   NUM_CH   number of mux channels (power of two, <= 8)
//   SCK_DIV  SCK half-period in clk cycles (>= 1)
//   CONV_CYC clk cycles from ADC_CONVST to the first SCK (>= 1)
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   enable              scan while high; low clears overrun
//   ch_mask             channels to scan, bit i = channel i
//   uni                 UNI bit of the config word (1 = unipolar)
//   sample_data/ch      result and its channel
//   sample_valid/ready  output stream handshake
//   overrun             sticky, a finished result was dropped
//   ADC_CONVST/SCK/SDI  registered ADC pin drives
//   ADC_SDO             serial data from the ADC
//
// Optional build macro ADC_AVG_EN: each channel is held for four accepted
// frames and the truncated mean of those four results is emitted instead of
// one result per frame.
// ---------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int DATA_W   = 12,
    parameter int NUM_CH   = 8,
    parameter int SCK_DIV  = 2,
    parameter int CONV_CYC = 80
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              uni,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              ADC_CONVST,
    output logic              ADC_SCK,
    output logic              ADC_SDI,
    input  logic              ADC_SDO
);

    localparam int PH_W   = (SCK_DIV > 1) ? $clog2(2 * SCK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int WAIT_W = $clog2(CONV_CYC + 1);

    localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(SCK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * SCK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CONV_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_CONV_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [PH_W-1:0]     ph;
    logic [BIT_W-1:0]    bit_cnt;
    logic [5:0]          sdi_sr;
    logic [DATA_W-1:0]   shift_reg;
    logic [2:0]          cur_ch;     // channel configured in the current frame
    logic [2:0]          tag_ch;     // channel whose data is shifting in now
    logic                primed;

    logic                mask_any;
    logic [2:0]          nxt_ch;
    logic                adv;        // cur_ch may move on at the next CONVST
    logic                deliver;
    logic [DATA_W-1:0]   deliver_data;

    // Lowest set mask bit strictly above cur, else the lowest set bit overall.
    function automatic logic [2:0] pick_next(input logic [NUM_CH-1:0] m,
                                             input logic [2:0]        cur);
        logic [2:0] above;
        logic [2:0] lowest;
        logic       has_above;
        above     = cur;
        lowest    = cur;
        has_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest = 3'(i);
                if (i > int'(cur)) begin
                    above     = 3'(i);
                    has_above = 1'b1;
                end
            end
        end
        return has_above ? above : lowest;
    endfunction

    // ADC config word, shifted MSB first: S/D, O/S, S1, S0, UNI, SLP.
    function automatic logic [5:0] cfg_word(input logic [2:0] ch, input logic u);
        return {1'b1, ch[0], ch[2], ch[1], u, 1'b0};
    endfunction

    assign mask_any = |ch_mask;
    assign nxt_ch   = pick_next(ch_mask, cur_ch);

`ifdef ADC_AVG_EN
    logic [DATA_W+1:0] acc;
    logic [1:0]        avg_cnt;
    logic [DATA_W+1:0] acc_sum;
    logic              take;

    assign acc_sum = acc + {2'b00, shift_reg};
    // After a channel switch the data still belongs to the old channel, so
    // only frames whose tag matches the configured channel are accumulated.
    assign take    = primed && (tag_ch == cur_ch);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        deliver      = 1'b0;
        deliver_data = acc_sum[DATA_W+1:2];
        if (state == S_DONE && take && avg_cnt == 2'd3) begin
            deliver = 1'b1;
        end
    end
`else
    assign adv = 1'b1;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        deliver      = 1'b0;
        deliver_data = shift_reg;
        if (state == S_DONE && primed) begin
            deliver = 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            ph           <= '0;
            bit_cnt      <= '0;
            sdi_sr       <= '0;
            shift_reg    <= '0;
            cur_ch       <= '0;
            tag_ch       <= '0;
            primed       <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            ADC_CONVST   <= 1'b0;
            ADC_SCK      <= 1'b0;
            ADC_SDI      <= 1'b0;
`ifdef ADC_AVG_EN
            acc          <= '0;
            avg_cnt      <= '0;
            adv          <= 1'b1;
`endif
        end else begin
            // NOTE: the handshake clear comes first; a DONE reload below is a
            // later non-blocking assignment to the same register and wins.
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (deliver) begin
                if (!sample_valid || sample_ready) begin
                    sample_data  <= deliver_data;
                    sample_ch    <= tag_ch;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (!enable) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (enable && mask_any) begin
                        state      <= S_CONVST;
                        ADC_CONVST <= 1'b1;
                    end
                end

                S_CONVST: begin
                    ADC_CONVST <= 1'b0;
                    tag_ch     <= cur_ch;
                    if (adv) begin
                        cur_ch <= nxt_ch;
                        sdi_sr <= cfg_word(nxt_ch, uni);
                    end else begin
                        sdi_sr <= cfg_word(cur_ch, uni);
                    end
`ifdef ADC_AVG_EN
                    adv        <= 1'b0;
`endif
                    wait_cnt   <= '0;
                    state      <= S_CONV_WAIT;
                end

                S_CONV_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state   <= S_SHIFT;
                        ph      <= '0;
                        bit_cnt <= '0;
                        ADC_SDI <= sdi_sr[5];
                        sdi_sr  <= {sdi_sr[4:0], 1'b0};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    // SDO is captured on the same edge that raises SCK.
                    if (ph == PH_RISE) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], ADC_SDO};
                    end
                    if (ph == PH_LAST) begin
                        ph      <= '0;
                        ADC_SCK <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= S_DONE;
                            ADC_SDI <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            ADC_SDI <= sdi_sr[5];
                            sdi_sr  <= {sdi_sr[4:0], 1'b0};
                        end
                    end else begin
                        ph <= ph + 1'b1;
                        if (ph == PH_RISE) begin
                            ADC_SCK <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    primed <= 1'b1;
`ifdef ADC_AVG_EN
                    if (take) begin
                        if (avg_cnt == 2'd3) begin
                            acc     <= '0;
                            avg_cnt <= '0;
                            adv     <= 1'b1;
                        end else begin
                            acc     <= acc_sum;
                            avg_cnt <= avg_cnt + 1'b1;
                        end
                    end
`endif
                    if (enable && mask_any) begin
                        state      <= S_CONVST;
                        ADC_CONVST <= 1'b1;
                    end else begin
                        // The ADC pipeline is stale after idling, so the next
                        // run starts with a discarded priming frame.
                        state  <= S_IDLE;
                        primed <= 1'b0;
`ifdef ADC_AVG_EN
                        acc     <= '0;
                        avg_cnt <= '0;
                        adv     <= 1'b1;
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_ctrl
//
// Directed bench for adc_scan_ctrl. The main instance uses default parameters
// (130-cycle frames); two extra instances run SCK_DIV=1 and SCK_DIV=3.
// A behavioural ADC model decodes the config word sent in each frame and
// returns that channel's programmed value during the following frame.
// ---------------------------------------------------------------------------
module tb_adc_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  ch_mask;
    logic        uni;
    logic        sample_ready;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic        overrun;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        adc_sdo = 1'b0;

    // Side instances for the SCK divider checks.
    logic        en_d;
    logic [11:0] data_d1, data_d3;
    logic [2:0]  ch_d1, ch_d3;
    logic        valid_d1, valid_d3, ovr_d1, ovr_d3;
    logic        conv_d1, conv_d3, sck_d1, sck_d3, sdi_d1, sdi_d3;
    logic        sdo_d1 = 1'b0;
    logic        sdo_d3 = 1'b0;

    int checks = 0;
    int errors = 0;

    adc_scan_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask), .uni(uni),
        .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun),
        .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI), .ADC_SDO(adc_sdo)
    );

    adc_scan_ctrl #(.SCK_DIV(1)) u_div1 (
        .clk(clk), .reset_n(reset_n), .enable(en_d), .ch_mask(8'h01), .uni(1'b1),
        .sample_data(data_d1), .sample_ch(ch_d1), .sample_valid(valid_d1),
        .sample_ready(1'b0), .overrun(ovr_d1),
        .ADC_CONVST(conv_d1), .ADC_SCK(sck_d1), .ADC_SDI(sdi_d1), .ADC_SDO(sdo_d1)
    );

    adc_scan_ctrl #(.SCK_DIV(3)) u_div3 (
        .clk(clk), .reset_n(reset_n), .enable(en_d), .ch_mask(8'h01), .uni(1'b1),
        .sample_data(data_d3), .sample_ch(ch_d3), .sample_valid(valid_d3),
        .sample_ready(1'b0), .overrun(ovr_d3),
        .ADC_CONVST(conv_d3), .ADC_SCK(sck_d3), .ADC_SDI(sdi_d3), .ADC_SDO(sdo_d3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ADC model for the main instance ----------------
    logic [11:0] ch_val [8];
    logic [11:0] seq_val [8];
    bit          use_seq = 1'b0;
    int          frame_idx = 0;
    logic [5:0]  cfg_cur = 6'd0;   // config bits captured in the running frame
    logic [5:0]  cfg_last = 6'd0;  // config sent in the previous frame
    logic [11:0] sdo_word = 12'd0;
    int          sck_rises = 0;
    int          last_rises = 0;
    int          conv_count = 0;

    always @(posedge ADC_CONVST) begin
        cfg_last   = cfg_cur;
        last_rises = sck_rises;
        sck_rises  = 0;
        conv_count++;
        if (use_seq) sdo_word = (frame_idx < 8) ? seq_val[frame_idx] : 12'd0;
        else         sdo_word = ch_val[{cfg_cur[3], cfg_cur[2], cfg_cur[4]}];
        frame_idx++;
        adc_sdo = sdo_word[11];
    end

    always @(posedge ADC_SCK) begin
        if (sck_rises < 6) cfg_cur[5 - sck_rises] = ADC_SDI;
        sck_rises++;
    end

    always @(negedge ADC_SCK) begin
        sdo_word = sdo_word << 1;
        adc_sdo  = sdo_word[11];
    end

    // ---------------- fixed-pattern ADC models for divider instances ----------------
    logic [11:0] w1 = 12'd0;
    logic [11:0] w3 = 12'd0;
    always @(posedge conv_d1) begin w1 = 12'h96B; sdo_d1 = w1[11]; end
    always @(negedge sck_d1)  begin w1 = w1 << 1; sdo_d1 = w1[11]; end
    always @(posedge conv_d3) begin w3 = 12'h3C5; sdo_d3 = w3[11]; end
    always @(negedge sck_d3)  begin w3 = w3 << 1; sdo_d3 = w3[11]; end

    // ---------------- helpers ----------------
    task automatic do_reset();
        enable  = 1'b0;
        en_d    = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Counts negedges until sample_valid is seen; n == limit means timeout.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (sample_valid) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        enable = 1'b0; en_d = 1'b0; ch_mask = 8'h00; uni = 1'b0; sample_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sample_valid, overrun, ADC_CONVST, ADC_SCK, ADC_SDI} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {sample_valid, overrun, ADC_CONVST, ADC_SCK, ADC_SDI});
        end
        checks++;
        if ({sample_data, sample_ch} !== 15'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%0d expected 000/0", sample_data, sample_ch);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_channel();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) ch_val[i] = 12'h0F0;
        ch_val[0] = 12'hA5C;
        ch_mask = 8'h01; uni = 1'b1; sample_ready = 1'b1;
        enable = 1'b1;
        wait_valid(1000, n);
        checks++;
        if (n != 261) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles expected 261", n);
        end
        checks++;
        if (sample_data !== 12'hA5C || sample_ch !== 3'd0) begin
            errors++;
            $display("FAIL single_data: got %h/%0d expected a5c/0", sample_data, sample_ch);
        end
        checks++;
        if (cfg_last !== 6'b100010) begin
            errors++;
            $display("FAIL single_cfg: got %b expected 100010", cfg_last);
        end
        checks++;
        if (last_rises != 12) begin
            errors++;
            $display("FAIL single_sck_rises: got %0d expected 12", last_rises);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake: valid got %b expected 0", sample_valid);
        end
    endtask

    // cur_ch resets to 0, so the first configured channel is the lowest set
    // bit strictly above 0 (ch2); its data is the first delivered sample.
    task automatic test_round_robin();
        int n;
        logic [2:0] exp_ch [5];
        exp_ch[0] = 3'd2; exp_ch[1] = 3'd5; exp_ch[2] = 3'd7; exp_ch[3] = 3'd0; exp_ch[4] = 3'd2;
        do_reset();
        for (int i = 0; i < 8; i++) ch_val[i] = 12'h300 + 12'(i * 17);
        ch_mask = 8'b1010_0101; uni = 1'b0; sample_ready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid(400, n);
            if (k == 0) begin
                checks++;
                if (cfg_last !== 6'b111000) begin
                    errors++;
                    $display("FAIL rr_cfg_ch5: got %b expected 111000", cfg_last);
                end
            end
            checks++;
            if (n >= 400 || sample_ch !== exp_ch[k] || sample_data !== ch_val[exp_ch[k]]) begin
                errors++;
                $display("FAIL rr_sample%0d: got ch %0d data %h expected ch %0d data %h",
                         k, sample_ch, sample_data, exp_ch[k], ch_val[exp_ch[k]]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        ch_val[0] = 12'h111;
        ch_mask = 8'h01; uni = 1'b1; sample_ready = 1'b0;
        enable = 1'b1;
        wait_valid(400, n);
        checks++;
        if (n != 261 || sample_data !== 12'h111) begin
            errors++;
            $display("FAIL bp_first: got %0d cycles data %h expected 261 cycles data 111", n, sample_data);
        end
        ch_val[0] = 12'h222;   // frame 3 is already loaded; frame 4 onwards returns 222
        repeat (129) @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_overrun_early: got %b expected 0", overrun);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || sample_valid !== 1'b1 || sample_data !== 12'h111) begin
            errors++;
            $display("FAIL bp_overrun_set: ovr %b valid %b data %h expected 1 1 111",
                     overrun, sample_valid, sample_data);
        end
        repeat (130) @(negedge clk);
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== 12'h111) begin
            errors++;
            $display("FAIL bp_held: valid %b data %h expected 1 111", sample_valid, sample_data);
        end
        sample_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid %b ovr %b expected 0 1", sample_valid, overrun);
        end
        repeat (129) @(negedge clk);
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== 12'h222 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_next: valid %b data %h ovr %b expected 1 222 1",
                     sample_valid, sample_data, overrun);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_overrun_clear: got %b expected 0", overrun);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        int conv0;
        int guard;
        do_reset();
        ch_val[0] = 12'h5A5;
        ch_mask = 8'h01; uni = 1'b1; sample_ready = 1'b1;
        enable = 1'b1;
        wait_valid(400, n);
        guard = 0;
        while (sck_rises < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        enable = 1'b0;
        wait_valid(200, n);
        checks++;
        if (n >= 200 || sample_data !== 12'h5A5) begin
            errors++;
            $display("FAIL drop_last_sample: got %0d cycles data %h expected <200 cycles data 5a5", n, sample_data);
        end
        conv0 = conv_count;
        repeat (300) @(negedge clk);
        checks++;
        if (conv_count != conv0 || ADC_SCK !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got %0d new conversions expected 0", conv_count - conv0);
        end
        enable = 1'b1;
        wait_valid(1000, n);
        checks++;
        if (n != 261) begin
            errors++;
            $display("FAIL drop_reprime: got %0d cycles expected 261", n);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        do_reset();
        ch_mask = 8'h01; uni = 1'b1; sample_ready = 1'b1;
        enable = 1'b1;
        guard = 0;
        while (ADC_SCK !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (ADC_SCK !== 1'b1 || ADC_SDI !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: sck %b sdi %b expected 1 1", ADC_SCK, ADC_SDI);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ADC_CONVST, ADC_SCK, ADC_SDI} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async: got %b expected 000", {ADC_CONVST, ADC_SCK, ADC_SDI});
        end
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sck_div(input int div);
        int guard;
        int cyc;
        int rises;
        int high;
        int bad;
        int last_rise;
        logic prev;
        logic s;
        logic c;
        guard = 0;
        c = (div == 1) ? conv_d1 : conv_d3;
        while (c !== 1'b1 && guard < 400) begin
            @(negedge clk);
            c = (div == 1) ? conv_d1 : conv_d3;
            guard++;
        end
        cyc = 0; rises = 0; high = 0; bad = 0; last_rise = -1; prev = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            s = (div == 1) ? sck_d1 : sck_d3;
            c = (div == 1) ? conv_d1 : conv_d3;
            if (s) high++;
            if (s && !prev) begin
                if (last_rise >= 0 && cyc - last_rise != 2 * div) bad++;
                last_rise = cyc;
                rises++;
            end
            prev = s;
        end while (c !== 1'b1 && cyc < 400);
        checks++;
        if (rises != 12 || bad != 0 || high != 12 * div) begin
            errors++;
            $display("FAIL div%0d_sck: rises %0d bad periods %0d high %0d expected 12 0 %0d",
                     div, rises, bad, high, 12 * div);
        end
        checks++;
        if (cyc != 82 + 24 * div) begin
            errors++;
            $display("FAIL div%0d_frame: got %0d cycles expected %0d", div, cyc, 82 + 24 * div);
        end
    endtask

    task automatic test_div_results();
        int guard;
        do_reset();
        en_d = 1'b1;
        test_sck_div(1);
        test_sck_div(3);
        guard = 0;
        while (!(valid_d1 && valid_d3) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (valid_d1 !== 1'b1 || data_d1 !== 12'h96B) begin
            errors++;
            $display("FAIL div1_data: valid %b data %h expected 1 96b", valid_d1, data_d1);
        end
        checks++;
        if (valid_d3 !== 1'b1 || data_d3 !== 12'h3C5) begin
            errors++;
            $display("FAIL div3_data: valid %b data %h expected 1 3c5", valid_d3, data_d3);
        end
        en_d = 1'b0;
    endtask

`ifdef ADC_AVG_EN
    task automatic test_avg();
        int n;
        do_reset();
        seq_val[0] = 12'hFFF;   // priming frame, must not enter the average
        seq_val[1] = 12'd100;
        seq_val[2] = 12'd101;
        seq_val[3] = 12'd102;
        seq_val[4] = 12'd104;
        for (int i = 5; i < 8; i++) seq_val[i] = 12'd0;
        frame_idx = 0;
        use_seq = 1'b1;
        ch_mask = 8'h01; uni = 1'b1; sample_ready = 1'b1;
        enable = 1'b1;
        wait_valid(1000, n);
        checks++;
        if (n != 651 || sample_data !== 12'd101 || sample_ch !== 3'd0) begin
            errors++;
            $display("FAIL avg_result: got %0d cycles data %0d ch %0d expected 651 cycles data 101 ch 0",
                     n, sample_data, sample_ch);
        end
        use_seq = 1'b0;
        enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_AVG_EN
        test_avg();
`else
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_enable_drop();
`endif
        test_reset_mid_frame();
        test_div_results();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
